hazard_stall_controller: RTL and testbench

- Pipeline hazard and sequencing controller for the 5-stage MIPS core.
- Generates the PC and IF/ID write enables and the IF/ID and ID/EX flush controls for three cases: load-use stalls, taken-branch/jump flushes, and HI/LO interlock while the multi-cycle mult/div unit is busy.
- Owns the mult/div busy FSM and cycle counter. Complements the forwarding path: it stalls only where forwarding cannot resolve the hazard.

---
 rtl/hazard_stall_controller.sv | 134 +++++++++++++
 tb/tb_hazard_stall_controller.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_controller
// Purpose  : Load-use / branch / HI-LO interlock control for the 5-stage MIPS
//            pipeline; owns the mult/div busy FSM. Optional stall counter is
//            built when HAZARD_PERF_CNT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module hazard_stall_controller #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_IF_ID_out,
    input  logic [31:0] IR_ID_EX_out,
    input  logic        MemRead_ID_EX_out,
    input  logic        BranchTaken_EX,
    input  logic        Jump_ID,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Flush,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cycles
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_mult_last = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_div_last  = CNT_W'(DIV_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [5:0] w_id_op, w_id_funct, w_ex_op, w_ex_funct;
    logic [4:0] w_id_rs, w_id_rt, w_ex_rt;
    logic       w_ex_muldiv, w_id_hilo_use, w_id_uses_rt;
    logic       w_load_use, w_md_stall, w_stall;

    assign w_id_op    = IR_IF_ID_out[31:26];
    assign w_id_rs    = IR_IF_ID_out[25:21];
    assign w_id_rt    = IR_IF_ID_out[20:16];
    assign w_id_funct = IR_IF_ID_out[5:0];
    assign w_ex_op    = IR_ID_EX_out[31:26];
    assign w_ex_rt    = IR_ID_EX_out[20:16];
    assign w_ex_funct = IR_ID_EX_out[5:0];

    logic w_unused;
    assign w_unused = &{1'b0, IR_IF_ID_out[15:6], IR_ID_EX_out[25:21], IR_ID_EX_out[15:6]};

    assign w_ex_muldiv   = (w_ex_op == 6'h00) && (w_ex_funct[5:2] == 4'b0110);
    assign w_id_hilo_use = (w_id_op == 6'h00) &&
                           ((w_id_funct == 6'h10) || (w_id_funct == 6'h12) ||
                            (w_id_funct[5:2] == 4'b0110));
    assign w_id_uses_rt  = (w_id_op == 6'h00) || (w_id_op == 6'h04) ||
                           (w_id_op == 6'h05) || (w_id_op == 6'h2B);

    assign w_load_use = !reset && MemRead_ID_EX_out && (w_ex_rt != 5'd0) &&
                        ((w_ex_rt == w_id_rs) || (w_id_uses_rt && (w_ex_rt == w_id_rt)));

    // HI/LO is only unsafe while the unit still has cycles left; on the final
    // (md_done) cycle the result is written and the reader may proceed.
    assign md_start   = (state_q == S_IDLE) && w_ex_muldiv && !reset;
    assign w_md_stall = !reset && w_id_hilo_use &&
                        (md_start || ((state_q == S_BUSY) && (cnt_q != '0)));
    assign w_stall    = (w_load_use || w_md_stall) && !BranchTaken_EX;

    assign PC_Write    = !w_stall;
    assign IF_ID_Write = !w_stall;
    assign ID_EX_Flush = !reset && (w_stall || BranchTaken_EX);
    assign IF_ID_Flush = !reset && (BranchTaken_EX || (Jump_ID && !w_stall));

    assign md_busy = !reset && (state_q == S_BUSY);
    assign md_done = !reset && (state_q == S_BUSY) && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (md_start) begin
                    state_d = S_BUSY;
                    cnt_d   = w_ex_funct[1] ? c_div_last : c_mult_last;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else if (w_stall) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign stall_cycles = perf_q;
`else
    assign stall_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_controller
// Purpose  : Directed + randomized bench for hazard_stall_controller against a
//            countdown-based behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_stall_controller;

    localparam int c_MULT = 4;
    localparam int c_DIV  = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir_id, ir_ex;
    logic        mem_rd, br_tk, jmp;
    logic        pc_wr, ifid_wr, ifid_fl, idex_fl, md_start, md_busy, md_done;
    logic [31:0] stall_cycles;

    int          n_checks = 0;
    int          n_errors = 0;

    int          busy_left = 0;
    logic [31:0] perf_m = '0;
    int          obs_stalls;

    always #5 clk = ~clk;

    hazard_stall_controller #(
        .MULT_CYCLES(c_MULT),
        .DIV_CYCLES (c_DIV),
        .CNT_W      (6)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .IR_IF_ID_out     (ir_id),
        .IR_ID_EX_out     (ir_ex),
        .MemRead_ID_EX_out(mem_rd),
        .BranchTaken_EX   (br_tk),
        .Jump_ID          (jmp),
        .PC_Write         (pc_wr),
        .IF_ID_Write      (ifid_wr),
        .IF_ID_Flush      (ifid_fl),
        .ID_EX_Flush      (idex_fl),
        .md_start         (md_start),
        .md_busy          (md_busy),
        .md_done          (md_done),
        .stall_cycles     (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int funct);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] rand_instr();
        int a = $urandom_range(0, 3);
        int b = $urandom_range(0, 3);
        int d = $urandom_range(0, 3);
        case ($urandom_range(0, 9))
            0:       return rtype(a, b, d, 'h20);
            1:       return rtype(0, 0, d, 'h10);
            2:       return rtype(0, 0, d, 'h12);
            3:       return rtype(a, b, 0, 'h18 + $urandom_range(0, 3));
            4:       return itype('h23, a, b, $urandom_range(0, 255));
            5:       return itype('h2B, a, b, $urandom_range(0, 255));
            6:       return itype('h04 + $urandom_range(0, 1), a, b, 4);
            7:       return itype('h08, a, b, 1);
            8:       return rtype(a, 0, 0, 'h08);
            default: return 32'd0;
        endcase
    endfunction

    // One cycle: drive at negedge, compare mid-cycle, advance model on posedge.
    task automatic step(input logic [31:0] id, input logic [31:0] ex, input logic mr,
                        input logic bt, input logic jp, input logic rst);
        logic [5:0] idop, idfn, exop, exfn;
        logic [4:0] idrs, idrt, exrt;
        logic ex_md, hilo, urt, start, lu, mds, stl;
        @(negedge clk);
        ir_id = id; ir_ex = ex; mem_rd = mr; br_tk = bt; jmp = jp; reset = rst;
        #1;
        idop = id[31:26]; idrs = id[25:21]; idrt = id[20:16]; idfn = id[5:0];
        exop = ex[31:26]; exrt = ex[20:16]; exfn = ex[5:0];
        ex_md = (exop == 0) && (exfn >= 6'h18) && (exfn <= 6'h1B);
        hilo  = (idop == 0) && (idfn == 6'h10 || idfn == 6'h12 || (idfn >= 6'h18 && idfn <= 6'h1B));
        urt   = (idop == 0) || (idop == 6'h04) || (idop == 6'h05) || (idop == 6'h2B);
        start = !rst && (busy_left == 0) && ex_md;
        lu    = !rst && mr && (exrt != 0) && (exrt == idrs || (urt && exrt == idrt));
        mds   = !rst && hilo && (start || busy_left > 1);
        stl   = (lu || mds) && !bt;
        chk("PC_Write",    {31'd0, pc_wr},    {31'd0, !stl});
        chk("IF_ID_Write", {31'd0, ifid_wr},  {31'd0, !stl});
        chk("ID_EX_Flush", {31'd0, idex_fl},  {31'd0, !rst && (stl || bt)});
        chk("IF_ID_Flush", {31'd0, ifid_fl},  {31'd0, !rst && (bt || (jp && !stl))});
        chk("md_start",    {31'd0, md_start}, {31'd0, start});
        chk("md_busy",     {31'd0, md_busy},  {31'd0, !rst && busy_left > 0});
        chk("md_done",     {31'd0, md_done},  {31'd0, !rst && busy_left == 1});
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, perf_m);
`else
        chk("stall_cycles", stall_cycles, 32'd0);
`endif
        if (stl) obs_stalls++;
        @(posedge clk);
        if (rst)                busy_left = 0;
        else if (busy_left > 0) busy_left = busy_left - 1;
        else if (start)         busy_left = exfn[1] ? c_DIV : c_MULT;
        if (rst)      perf_m = '0;
        else if (stl) perf_m = perf_m + 1;
    endtask

    initial begin
        logic [31:0] ex_r;
        reset = 1'b1; ir_id = '0; ir_ex = '0; mem_rd = 0; br_tk = 0; jmp = 0;
        step(rtype(1, 2, 3, 'h18), rtype(1, 2, 3, 'h1A), 1'b1, 1'b0, 1'b1, 1'b1);
        step(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // load-use then mult/mflo: 1 + MULT_CYCLES stall cycles in total
        obs_stalls = 0;
        step(rtype(8, 10, 9, 'h20), itype('h23, 1, 8, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        step(rtype(8, 10, 9, 'h20), 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("loaduse_len", obs_stalls, 1);
        obs_stalls = 0;
        step(rtype(0, 0, 3, 'h12), rtype(1, 2, 0, 'h18), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < c_MULT; i++)
            step(rtype(0, 0, 3, 'h12), 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mult_stall_len", obs_stalls, c_MULT);
        @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_total", stall_cycles, 32'd5);
`else
        chk("perf_total", stall_cycles, 32'd0);
`endif

        // lw $0 never stalls; addi $8,$8,1 stalls through rs only
        step(rtype(0, 0, 9, 'h20), itype('h23, 1, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        step(itype('h08, 8, 8, 1), itype('h23, 1, 8, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        step(itype('h08, 8, 8, 1), 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // taken branch beats load-use
        step(rtype(8, 10, 9, 'h20), itype('h23, 1, 8, 0), 1'b1, 1'b1, 1'b1, 1'b0);

        // div with mflo waiting: DIV_CYCLES stall cycles
        obs_stalls = 0;
        step(rtype(0, 0, 3, 'h10), rtype(1, 2, 0, 'h1B), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < c_DIV; i++)
            step(rtype(0, 0, 3, 'h10), 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("div_stall_len", obs_stalls, c_DIV);

        // reset at busy cycle 10 aborts the divide; a later mult runs normally
        step(32'd0, rtype(1, 2, 0, 'h1A), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(rtype(0, 0, 3, 'h12), rtype(1, 2, 0, 'h19), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < c_MULT + 1; i++)
            step(rtype(0, 0, 3, 'h12), 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ex_r = rand_instr();
            step(rand_instr(), ex_r, (ex_r[31:26] == 6'h23) ? 1'b1 : 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 59) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
